// File: rtl/booth_seq_mul_if.sv
// Operand/product handshake bundle for booth_seq_mul.
// master = operand producer / product consumer, slave = the multiplier.
interface booth_seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   a_signed;
    logic                   b_signed;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, a, b, a_signed, b_signed, flush, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, flush, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a
// 2*WIDTH-bit accumulator, operands and product over valid/ready handshakes.
// WIDTH must be even and >= 4.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    booth_seq_mul_if.slave  bus
);
    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int CW     = $clog2(DIGITS);
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;

    // M carries two extra bits so that 2M never overflows.
    logic [WIDTH+1:0]   m_q;
    // R = {e, e, b, 0}: the trailing zero is the implicit b[-1] and the two
    // extension bits make the top digit(s) correct for unsigned b.
    logic [WIDTH+2:0]   r_q;
    logic [PW-1:0]      acc_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      product_q;

    logic               accept;
    logic               last;
    logic [WIDTH+2:0]   r_shift;
    logic [2:0]         code;
    logic               dig_zero;
    logic               dig_neg;
    logic               dig_dbl;
    logic [WIDTH+1:0]   mag;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_nxt;

    // Handshake qualifiers; flush masks an incoming operand in the same cycle.
    always_comb begin
        accept = (state == IDLE) && bus.in_valid && !bus.flush;
        last   = (state == CALC) && (cnt_q == CW'(DIGITS - 1));
    end

    // Booth digit decode and partial-product generation for the current digit.
    always_comb begin
        r_shift  = r_q >> {cnt_q, 1'b0};
        code     = r_shift[2:0];
        dig_zero = (code == 3'b000) || (code == 3'b111);
        dig_neg  = code[2] && (code != 3'b111);
        dig_dbl  = (code == 3'b011) || (code == 3'b100);
        mag      = dig_dbl ? {m_q[WIDTH:0], 1'b0} : m_q;
        pp_ext   = {{(PW - WIDTH - 2){mag[WIDTH+1]}}, mag};
        if (dig_neg)
            pp_ext = '0 - pp_ext;
        if (dig_zero)
            pp_ext = '0;
        // Bits shifted past 2*WIDTH are dropped; the exact product always fits.
        pp      = pp_ext << {cnt_q, 1'b0};
        acc_nxt = acc_q + pp;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush overrides everything but reset.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) state_nxt = CALC;
                CALC:    if (last)         state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status outputs are pure state decodes, so they are glitch-free and
    // have no combinational path from any input.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.product   = product_q;
    end

    // Datapath: latch operands on accept, accumulate one digit per CALC cycle,
    // capture the result on the last digit. product survives a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            m_q   <= {{2{bus.a_signed & bus.a[WIDTH-1]}}, bus.a};
            r_q   <= {{2{bus.b_signed & bus.b[WIDTH-1]}}, bus.b, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state == CALC) begin
            acc_q <= acc_nxt;
            if (last) begin
                cnt_q     <= '0;
                product_q <= acc_nxt;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul: WIDTH=32 and WIDTH=8 instances.
module tb_booth_seq_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    booth_seq_mul_if #(.WIDTH(32)) b32 ();
    booth_seq_mul_if #(.WIDTH(8))  b8 ();

    booth_seq_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    booth_seq_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    // One full 32-bit transaction; lat = edges from accept to out_valid
    // (100 means it never came).
    task automatic mul32(input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic bs,
                         output logic [63:0] p, output int lat);
        int w = 0;
        b32.a = a; b32.b = b; b32.a_signed = as; b32.b_signed = bs;
        b32.in_valid = 1'b1;
        while (!b32.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        lat = 0;
        while (!b32.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        p = b32.product;
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        input logic as, input logic bs,
                        output logic [15:0] p, output int lat);
        int w = 0;
        b8.a = a; b8.b = b; b8.a_signed = as; b8.b_signed = bs;
        b8.in_valid = 1'b1;
        while (!b8.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        p = b8.product;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got rdy=%b vld=%b busy=%b, want 1 0 0",
                     b32.in_ready, b32.out_valid, b32.busy);
        end
        tests++;
        if (b32.product !== 64'h0) begin
            fails++;
            $display("FAIL reset_product: got %h, want 0", b32.product);
        end
        tests++;
        if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.product !== 16'h0) begin
            fails++;
            $display("FAIL reset_w8: got rdy=%b vld=%b prod=%h, want 1 0 0000",
                     b8.in_ready, b8.out_valid, b8.product);
        end
    endtask

    task automatic test_unsigned_max();
        logic [63:0] p; int lat;
        mul32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, p, lat);
        tests++;
        if (p !== 64'hFFFFFFFE00000001) begin
            fails++;
            $display("FAIL umax_product: got %h, want fffffffe00000001", p);
        end
        tests++;
        if (lat != 17) begin
            fails++;
            $display("FAIL umax_latency: got %0d, want 17", lat);
        end
    endtask

    task automatic test_signed_corners();
        logic [63:0] p; int lat;
        mul32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, p, lat);
        tests++;
        if (p !== 64'h0000000000000001) begin
            fails++;
            $display("FAIL neg1_sq: got %h, want 0000000000000001", p);
        end
        mul32(32'h80000000, 32'h80000000, 1'b1, 1'b1, p, lat);
        tests++;
        if (p !== 64'h4000000000000000) begin
            fails++;
            $display("FAIL min_sq: got %h, want 4000000000000000", p);
        end
        mul32(32'h80000000, 32'h00000001, 1'b1, 1'b1, p, lat);
        tests++;
        if (p !== 64'hFFFFFFFF80000000) begin
            fails++;
            $display("FAIL min_x1: got %h, want ffffffff80000000", p);
        end
    endtask

    task automatic test_mixed();
        logic [63:0] p; int lat;
        mul32(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, p, lat);
        tests++;
        if (p !== 64'hFFFFFFFE00000002) begin
            fails++;
            $display("FAIL mixed_su: got %h, want fffffffe00000002", p);
        end
        // Operands swapped together with their flags: same product.
        mul32(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, p, lat);
        tests++;
        if (p !== 64'hFFFFFFFE00000002) begin
            fails++;
            $display("FAIL mixed_us: got %h, want fffffffe00000002", p);
        end
        mul32(32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b1, p, lat);
        tests++;
        if (p !== 64'hFFFFFFFFFFFFFFFD) begin
            fails++;
            $display("FAIL mixed_3xm1: got %h, want fffffffffffffffd", p);
        end
    endtask

    task automatic test_w8();
        logic [15:0]       p;
        logic [15:0]       exp;
        logic signed [8:0] sa, sb;
        logic signed [17:0] pr;
        logic [7:0]        vals [10];
        int lat;
        vals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'h33};
        mul8(8'h7F, 8'h81, 1'b1, 1'b1, p, lat);
        tests++;
        if (p !== 16'hC0FF) begin
            fails++;
            $display("FAIL w8_7fx81: got %h, want c0ff", p);
        end
        tests++;
        if (lat != 5) begin
            fails++;
            $display("FAIL w8_latency: got %0d, want 5", lat);
        end
        for (int mode = 0; mode < 4; mode++) begin
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < 10; j++) begin
                    logic as, bs;
                    as = mode[1];
                    bs = mode[0];
                    sa = {as & vals[i][7], vals[i]};
                    sb = {bs & vals[j][7], vals[j]};
                    pr = sa * sb;
                    exp = pr[15:0];
                    mul8(vals[i], vals[j], as, bs, p, lat);
                    tests++;
                    if (p !== exp || lat != 5) begin
                        fails++;
                        $display("FAIL w8_sweep %h*%h as=%b bs=%b: got %h lat %0d, want %h lat 5",
                                 vals[i], vals[j], as, bs, p, lat, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        b32.a = 32'h00010000; b32.b = 32'h00010000;
        b32.a_signed = 1'b0; b32.b_signed = 1'b0;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        while (!b32.out_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        tests++;
        if (w != 17) begin
            fails++;
            $display("FAIL bp_latency: got %0d, want 17", w);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                b32.a = 32'h00000002; b32.b = 32'h00000002;
                b32.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            b32.in_valid = 1'b0;
            tests++;
            if (b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 ||
                b32.product !== 64'h0000000100000000) begin
                fails++;
                $display("FAIL bp_hold cyc %0d: got vld=%b rdy=%b prod=%h, want 1 0 0000000100000000",
                         i, b32.out_valid, b32.in_ready, b32.product);
            end
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        tests++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     b32.out_valid, b32.in_ready, b32.busy);
        end
    endtask

    task automatic test_flush();
        logic [63:0] prev, p;
        int lat;
        int seen = 0;
        prev = b32.product;
        b32.a = 32'h0000FFFF; b32.b = 32'h0000FFFF;
        b32.a_signed = 1'b0; b32.b_signed = 1'b0;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        b32.flush = 1'b1;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        tests++;
        if (b32.in_ready !== 1'b1 || b32.busy !== 1'b0 || b32.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: got rdy=%b busy=%b vld=%b, want 1 0 0",
                     b32.in_ready, b32.busy, b32.out_valid);
        end
        tests++;
        if (b32.product !== prev) begin
            fails++;
            $display("FAIL flush_product_kept: got %h, want %h", b32.product, prev);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (b32.out_valid || b32.busy) seen = 1;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_quiet: got activity %0d, want 0", seen);
        end
        mul32(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
        tests++;
        if (p !== 64'd15 || lat != 17) begin
            fails++;
            $display("FAIL flush_next_op: got %h lat %0d, want 000000000000000f lat 17", p, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] p;
        int lat;
        b32.a = 32'h12345678; b32.b = 32'h9ABCDEF0;
        b32.a_signed = 1'b1; b32.b_signed = 1'b1;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.busy !== 1'b0 ||
            b32.product !== 64'h0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b vld=%b busy=%b prod=%h, want 1 0 0 0",
                     b32.in_ready, b32.out_valid, b32.busy, b32.product);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mul32(32'd7, 32'd9, 1'b0, 1'b0, p, lat);
        tests++;
        if (p !== 64'd63 || lat != 17) begin
            fails++;
            $display("FAIL post_reset_op: got %h lat %0d, want 000000000000003f lat 17", p, lat);
        end
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.a = '0; b32.b = '0;
        b32.a_signed = 1'b0; b32.b_signed = 1'b0;
        b32.flush = 1'b0; b32.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0;
        b8.a_signed = 1'b0; b8.b_signed = 1'b0;
        b8.flush = 1'b0; b8.out_ready = 1'b0;
        #12;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_unsigned_max();
        test_signed_corners();
        test_mixed();
        test_w8();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
